// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Holds the FSM state encoding and the legal instruction-alignment settings.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } pc_state_e;

  localparam int IALIGN_32 = 32;
  localparam int IALIGN_16 = 16;

  // Address low bits that must be zero for a legal target.
  function automatic logic [1:0] align_mask(input int ialign);
    return (ialign == IALIGN_16) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_align_chk.sv
// Combinational alignment check of a redirect target against IALIGN.
// Only the two low address bits can ever matter, so only those are taken in.
module pc_align_chk
  import pc_gen_pkg::*;
#(
  parameter int IALIGN = IALIGN_32
) (
  input  logic [1:0] addr_lo,
  output logic       aligned
);

  assign aligned = ((addr_lo & align_mask(IALIGN)) == 2'b00);

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential advance, branch/trap/mret redirects,
// misaligned-target fault capture, with a one-cycle boot bubble after reset.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               IALIGN       = IALIGN_32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] alu,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  input  logic            stall,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_4,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_fault,
  output logic [XLEN-1:0] fault_addr
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic            misalign_q, misalign_d;
  logic            pc_valid_q, pc_valid_d;

  logic            alu_ok;
  logic            epc_ok;
  logic [XLEN-1:0] trap_target;

  pc_align_chk #(.IALIGN(IALIGN)) u_chk_alu (
    .addr_lo (alu[1:0]),
    .aligned (alu_ok)
  );

  pc_align_chk #(.IALIGN(IALIGN)) u_chk_epc (
    .addr_lo (epc_q[1:0]),
    .aligned (epc_ok)
  );

  // Trap vectors are trusted: misaligned low bits are simply dropped.
  assign trap_target = {trap_vector[XLEN-1:2], trap_vector[1:0] & ~align_mask(IALIGN)};

  assign pc_4 = pc_q + XLEN'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    fault_addr_d = fault_addr_q;
    misalign_d   = misalign_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (trap) begin
          pc_d  = trap_target;
          epc_d = pc_q;
        end else if (mret) begin
          if (epc_ok) begin
            pc_d = epc_q;
          end else begin
            state_d      = ST_FAULT;
            misalign_d   = 1'b1;
            fault_addr_d = epc_q;
          end
        end else if (pc_sel) begin
          if (alu_ok) begin
            pc_d = alu;
          end else begin
            state_d      = ST_FAULT;
            misalign_d   = 1'b1;
            fault_addr_d = alu;
          end
        end else if (pc_ready && !stall) begin
          pc_d = pc_4;
        end
      end

      ST_FAULT: begin
        // Only a trap can recover; branches and mret are ignored here.
        if (trap) begin
          state_d    = ST_RUN;
          pc_d       = trap_target;
          epc_d      = pc_q;
          misalign_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    pc_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      fault_addr_q <= '0;
      misalign_q   <= 1'b0;
      pc_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      fault_addr_q <= fault_addr_d;
      misalign_q   <= misalign_d;
      pc_valid_q   <= pc_valid_d;
    end
  end

  assign pc             = pc_q;
  assign epc            = epc_q;
  assign fault_addr     = fault_addr_q;
  assign misalign_fault = misalign_q;
  assign pc_valid       = pc_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch-address rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_sel;
  logic [31:0] alu;
  logic        trap;
  logic [31:0] trap_vector;
  logic        mret;
  logic        stall;
  logic        pc_ready;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        pc_valid;
  logic [31:0] epc;
  logic        misalign_fault;
  logic [31:0] fault_addr;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  bit          m_booting;
  bit          m_faulted;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_faddr;

  pc_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_sel         (pc_sel),
    .alu            (alu),
    .trap           (trap),
    .trap_vector    (trap_vector),
    .mret           (mret),
    .stall          (stall),
    .pc_ready       (pc_ready),
    .pc             (pc),
    .pc_4           (pc_4),
    .pc_valid       (pc_valid),
    .epc            (epc),
    .misalign_fault (misalign_fault),
    .fault_addr     (fault_addr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_booting = 1'b1;
    m_faulted = 1'b0;
    m_pc      = 32'h0;
    m_epc     = 32'h0;
    m_faddr   = 32'h0;
  endtask

  // Next-state of the model for the inputs currently applied.
  task automatic model_step();
    logic [31:0] tgt;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_faulted) begin
      if (trap) begin
        m_epc     = m_pc;
        m_pc      = trap_vector - (trap_vector % 4);
        m_faulted = 1'b0;
      end
    end else if (trap) begin
      m_epc = m_pc;
      m_pc  = trap_vector - (trap_vector % 4);
    end else if (mret || pc_sel) begin
      tgt = mret ? m_epc : alu;
      if (tgt % 4 != 0) begin
        m_faulted = 1'b1;
        m_faddr   = tgt;
      end else begin
        m_pc = tgt;
      end
    end else if (pc_ready && !stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle_inputs();
    pc_sel      = 1'b0;
    alu         = 32'h0;
    trap        = 1'b0;
    trap_vector = 32'h0;
    mret        = 1'b0;
    stall       = 1'b0;
    pc_ready    = 1'b1;
  endtask

  // One clock with the applied inputs; inputs return to idle afterwards.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    $display("txn t=%0t pc=%h valid=%b epc=%h mf=%b fa=%h", $time, pc, pc_valid, epc,
             misalign_fault, fault_addr);
    idle_inputs();
  endtask

  task automatic redirect(input logic [31:0] target);
    pc_sel = 1'b1;
    alu    = target;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    n_vec++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || epc !== 32'h0 || fault_addr !== 32'h0 ||
        misalign_fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: pc=%h valid=%b epc=%h fa=%h mf=%b, required 0/0/0/0/0",
               pc, pc_valid, epc, fault_addr, misalign_fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_boot_sequence();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    n_vec++;
    if (pc_valid !== 1'b0 || pc !== 32'h0) begin
      n_err++;
      $display("FAIL boot_bubble: valid=%b pc=%h, required valid=0 pc=0", pc_valid, pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (pc_valid !== 1'b1 || pc !== exp_pc[i]) begin
        n_err++;
        $display("FAIL boot_seq[%0d]: valid=%b pc=%h, required valid=1 pc=%h",
                 i, pc_valid, pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_ready_hold();
    redirect(32'h10);
    for (int i = 0; i < 3; i++) begin
      pc_ready = 1'b0;
      tick();
      n_vec++;
      if (pc !== 32'h10) begin
        n_err++;
        $display("FAIL ready_hold[%0d]: pc=%h, required 00000010", i, pc);
      end
    end
    tick();
    n_vec++;
    if (pc !== 32'h14) begin
      n_err++;
      $display("FAIL ready_advance: pc=%h, required 00000014", pc);
    end
  endtask

  task automatic test_stall_redirect();
    redirect(32'h20);
    stall  = 1'b1;
    pc_sel = 1'b1;
    alu    = 32'h100;
    tick();
    n_vec++;
    if (pc !== 32'h100) begin
      n_err++;
      $display("FAIL stall_redirect: pc=%h, required 00000100", pc);
    end
    stall = 1'b1;
    tick();
    n_vec++;
    if (pc !== 32'h100) begin
      n_err++;
      $display("FAIL stall_hold: pc=%h, required 00000100", pc);
    end
  endtask

  task automatic test_trap_mret();
    redirect(32'h40);
    trap        = 1'b1;
    mret        = 1'b1;
    trap_vector = 32'h803;
    tick();
    n_vec++;
    if (pc !== 32'h800 || epc !== 32'h40) begin
      n_err++;
      $display("FAIL trap_wins: pc=%h epc=%h, required pc=00000800 epc=00000040", pc, epc);
    end
    mret = 1'b1;
    tick();
    n_vec++;
    if (pc !== 32'h40) begin
      n_err++;
      $display("FAIL mret_return: pc=%h, required 00000040", pc);
    end
  endtask

  task automatic test_misalign();
    redirect(32'h40);
    redirect(32'h102);
    n_vec++;
    if (misalign_fault !== 1'b1 || fault_addr !== 32'h102 || pc_valid !== 1'b0 ||
        pc !== 32'h40) begin
      n_err++;
      $display("FAIL misalign_enter: mf=%b fa=%h valid=%b pc=%h, required 1/00000102/0/00000040",
               misalign_fault, fault_addr, pc_valid, pc);
    end
    redirect(32'h300);
    mret = 1'b1;
    tick();
    n_vec++;
    if (pc !== 32'h40 || misalign_fault !== 1'b1 || pc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fault_ignores: pc=%h mf=%b valid=%b, required 00000040/1/0",
               pc, misalign_fault, pc_valid);
    end
    trap        = 1'b1;
    trap_vector = 32'h200;
    tick();
    n_vec++;
    if (pc !== 32'h200 || misalign_fault !== 1'b0 || pc_valid !== 1'b1 || epc !== 32'h40) begin
      n_err++;
      $display("FAIL fault_exit: pc=%h mf=%b valid=%b epc=%h, required 00000200/0/1/00000040",
               pc, misalign_fault, pc_valid, epc);
    end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    n_vec++;
    if (pc_4 !== 32'h0) begin
      n_err++;
      $display("FAIL pc4_wrap: pc_4=%h, required 00000000", pc_4);
    end
    tick();
    n_vec++;
    if (pc !== 32'h0 || pc_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pc_wrap: pc=%h valid=%b, required 00000000/1", pc, pc_valid);
    end
  endtask

  task automatic test_reset_in_fault();
    redirect(32'h55);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || epc !== 32'h0 || fault_addr !== 32'h0 ||
        misalign_fault !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: pc=%h valid=%b epc=%h fa=%h mf=%b, required all zero",
               pc, pc_valid, epc, fault_addr, misalign_fault);
    end
    #1;
    rst_n = 1'b1;
    test_boot_sequence();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      trap        = ($urandom_range(0, 15) == 0);
      trap_vector = $urandom();
      mret        = ($urandom_range(0, 11) == 0);
      pc_sel      = ($urandom_range(0, 5) == 0);
      alu         = ($urandom_range(0, 4) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      stall       = ($urandom_range(0, 3) == 0);
      pc_ready    = ($urandom_range(0, 3) != 0);
      model_step();
      @(posedge clk);
      #1;
      $display("txn t=%0t pc=%h valid=%b epc=%h mf=%b fa=%h", $time, pc, pc_valid, epc,
               misalign_fault, fault_addr);
      n_vec++;
      if (pc !== m_pc || pc_4 !== m_pc + 32'd4 || pc_valid !== !m_faulted ||
          epc !== m_epc || misalign_fault !== m_faulted || fault_addr !== m_faddr) begin
        n_err++;
        $display("FAIL random[%0d]: pc=%h pc4=%h v=%b epc=%h mf=%b fa=%h, required pc=%h pc4=%h v=%b epc=%h mf=%b fa=%h",
                 i, pc, pc_4, pc_valid, epc, misalign_fault, fault_addr,
                 m_pc, m_pc + 32'd4, !m_faulted, m_epc, m_faulted, m_faddr);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_boot_sequence();
    test_ready_hold();
    test_stall_redirect();
    test_trap_mret();
    test_misalign();
    test_wrap();
    test_reset_in_fault();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of all address ports.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter IALIGN, default 32, required target alignment in bits; legal values 32 and 16.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port pc_sel  input  1  1 = redirect to alu (taken branch or jump).
REQ-007 Port alu  input  XLEN  branch/jump target from the ALU.
REQ-008 Port trap  input  1  redirect to trap_vector and capture epc.
REQ-009 Port trap_vector  input  XLEN  trap handler address.
REQ-010 Port mret  input  1  redirect to epc.
REQ-011 Port stall  input  1  hold PC; no sequential advance.
REQ-012 Port pc_ready  input  1  instruction memory accepts the current pc.
REQ-013 Port pc  output  XLEN  current fetch address.
REQ-014 Port pc_4  output  XLEN  pc + 4, combinational from pc.
REQ-015 Port pc_valid  output  1  pc is a valid fetch request.
REQ-016 Port epc  output  XLEN  PC captured on trap.
REQ-017 Port misalign_fault  output  1  registered; target violated IALIGN.
REQ-018 Port fault_addr  output  XLEN  offending target of the last fault.

Function
REQ-019 FSM states SHALL be BOOT, RUN, FAULT; BOOT is entered on reset.
REQ-020 BOOT: pc_valid=0 for exactly one cycle with pc=RESET_VECTOR, then RUN unconditionally.
REQ-021 RUN: pc_valid=1; the next pc SHALL be chosen by priority trap > mret > pc_sel > (pc_ready & !stall ? pc_4 : pc).
REQ-022 Redirects (trap, mret, pc_sel) SHALL take effect on the next edge regardless of stall and pc_ready; the pending request is discarded.
REQ-023 Without a redirect, pc SHALL remain stable while pc_valid & !pc_ready, or while stall=1.
REQ-024 trap SHALL load epc with the current pc in the same edge that loads pc with trap_vector.
REQ-025 trap and mret asserted together: trap wins and epc is overwritten.
REQ-026 A pc_sel or mret target with addr[1:0]!=0 (IALIGN=32) or addr[0]!=0 (IALIGN=16) SHALL NOT load pc; the FSM enters FAULT, misalign_fault=1, fault_addr=target.
REQ-027 trap_vector is not alignment-checked; its low bits SHALL be forced to zero per IALIGN.
REQ-028 FAULT: pc_valid=0, pc held; only trap leaves FAULT (to RUN, clears misalign_fault); mret and pc_sel are ignored.
REQ-029 pc_4 SHALL wrap modulo 2^XLEN (all-ones minus 3 -> 0) with no flag.
REQ-030 All outputs except pc_4 SHALL be registered.

Reset
REQ-031 rst_n=0 SHALL asynchronously set pc=RESET_VECTOR, epc=0, fault_addr=0, misalign_fault=0, pc_valid=0, state=BOOT.
REQ-032 Reset mid-stall or in FAULT SHALL abandon all state identically; deassertion is synchronised by the integrator.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the IALIGN legal-value constants.
REQ-034 One sub-module, pc_align_chk (combinational target-alignment check), SHALL be instantiated once per checked target source.

Verification
REQ-035 Reset release, pc_ready=1 -> one cycle pc_valid=0 at 0x0, then pc 0x0, 0x4, 0x8 on consecutive cycles.
REQ-036 pc=0x10, pc_ready=0 for 3 cycles, then 1 -> pc holds 0x10 for three cycles, then 0x14.
REQ-037 pc=0x20, stall=1 and pc_sel=1, alu=0x100 -> next pc 0x100.
REQ-038 pc=0x40, trap=1, mret=1, trap_vector=0x803 -> pc=0x800, epc=0x40; next cycle mret=1 -> pc=0x40.
REQ-039 pc_sel=1, alu=0x102, IALIGN=32 -> misalign_fault=1, fault_addr=0x102, pc_valid=0, pc unchanged; trap with trap_vector=0x200 -> RUN, pc=0x200, fault cleared.
REQ-040 rst_n pulsed low asynchronously while in FAULT -> outputs at reset values immediately, BOOT sequence repeats.
